// File: rtl/program_loader.sv
// program_loader
//    Streams a program image into a synchronous RAM, reads it back to
//    verify a 16-bit additive checksum, then releases the CPU at BASE_ADDR.
//
// Ports
//    clk            sole clock, rising edge
//    rst_n          asynchronous active-low reset
//    start          one-cycle pulse, begins a load (honoured only in IDLE)
//    in_valid       image word stream valid
//    in_data        image word
//    in_last        marks the final word of the image
//    in_ready       word accepted when in_valid && in_ready
//    mem_addr       RAM word address (registered)
//    mem_wdata      RAM write data (registered)
//    mem_cs         RAM chip select (registered)
//    mem_we         RAM write enable (registered)
//    mem_oe         RAM output enable (registered)
//    mem_rdata      RAM read data, valid the cycle after the address
//    done           one-cycle pulse at end of load (verify or error)
//    pass           level, checksum matched; held until next start
//    word_count     words written in the current/last load
//    cpu_pc         CPU start address, constant BASE_ADDR
//    cpu_start      one-cycle pulse releasing the CPU on a passing load
//
// state  | meaning
// IDLE   | waiting for start, RAM deselected
// LOAD   | accepting words, one RAM write per accepted word
// VERIFY | pipelined read-back of every written word, summing read data
// DONE   | load finished, done/pass/cpu_start presented for one cycle
// ERROR  | image longer than MAX_WORDS, done presented with pass=0

module program_loader #(
   parameter int ADDR_WIDTH  = 14,
   parameter int DATA_WIDTH  = 16,
   parameter int BASE_ADDR   = 'h100,
   parameter int ADDR_STRIDE = 2,
   parameter int MAX_WORDS   = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  done,
   output logic                  pass,
   output logic [6:0]            word_count,
   output logic [15:0]           cpu_pc,
   output logic                  cpu_start
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_VERIFY,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic [6:0]            MAX_W    = 7'(MAX_WORDS);

   state_t                  state_q;
   logic                    in_ready_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic                    mem_cs_q;
   logic                    mem_we_q;
   logic                    mem_oe_q;
   logic                    done_q;
   logic                    pass_q;
   logic                    cpu_start_q;
   logic [6:0]              word_count_q;
   logic [6:0]              rd_idx_q;
   logic [15:0]             chk_wr_q;
   logic [15:0]             chk_rd_q;
   logic                    last_q;
   logic                    rd_vld_q;

   logic                    accept;
   logic                    full;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [15:0]             chk_wr_d;
   logic [15:0]             chk_rd_d;
   logic                    match;

   assign accept   = in_valid && in_ready_q && (state_q == S_LOAD);
   assign full     = (word_count_q == MAX_W);
   assign wr_addr  = BASE_A + STRIDE_A * ADDR_WIDTH'(word_count_q);
   assign rd_addr  = BASE_A + STRIDE_A * ADDR_WIDTH'(rd_idx_q);
   assign chk_wr_d = chk_wr_q + 16'(in_data);
   // The final read word is still on mem_rdata when the verdict is taken.
   assign chk_rd_d = chk_rd_q + 16'(mem_rdata);
   assign match    = (chk_rd_d == chk_wr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_oe_q     <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         cpu_start_q  <= 1'b0;
         word_count_q <= '0;
         rd_idx_q     <= '0;
         chk_wr_q     <= '0;
         chk_rd_q     <= '0;
         last_q       <= 1'b0;
         rd_vld_q     <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         cpu_start_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               mem_cs_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               mem_oe_q   <= 1'b0;
               in_ready_q <= 1'b0;
               if (start) begin
                  state_q      <= S_LOAD;
                  in_ready_q   <= 1'b1;
                  word_count_q <= '0;
                  chk_wr_q     <= '0;
                  chk_rd_q     <= '0;
                  pass_q       <= 1'b0;
                  last_q       <= 1'b0;
               end
            end

            S_LOAD: begin
               if (last_q) begin
                  // Final write is on the bus this cycle; first read follows it.
                  state_q    <= S_VERIFY;
                  last_q     <= 1'b0;
                  mem_cs_q   <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_oe_q   <= 1'b1;
                  mem_addr_q <= BASE_A;
                  rd_idx_q   <= 7'd1;
                  rd_vld_q   <= 1'b0;
               end else if (accept) begin
                  if (full) begin
                     // Image exceeds MAX_WORDS: drop the word, report failure.
                     state_q    <= S_ERROR;
                     in_ready_q <= 1'b0;
                     mem_cs_q   <= 1'b0;
                     mem_we_q   <= 1'b0;
                     mem_oe_q   <= 1'b0;
                     done_q     <= 1'b1;
                     pass_q     <= 1'b0;
                  end else begin
                     mem_cs_q     <= 1'b1;
                     mem_we_q     <= 1'b1;
                     mem_oe_q     <= 1'b0;
                     mem_addr_q   <= wr_addr;
                     mem_wdata_q  <= in_data;
                     word_count_q <= word_count_q + 7'd1;
                     chk_wr_q     <= chk_wr_d;
                     if (in_last) begin
                        last_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                     end
                  end
               end else begin
                  mem_cs_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  mem_oe_q <= 1'b0;
               end
            end

            S_VERIFY: begin
               rd_vld_q <= mem_cs_q && mem_oe_q;
               if (rd_vld_q) begin
                  chk_rd_q <= chk_rd_d;
               end
               if (!mem_cs_q) begin
                  // Reads exhausted and the last read word is present now.
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  pass_q      <= match;
                  cpu_start_q <= match;
               end else if (rd_idx_q == word_count_q) begin
                  mem_cs_q <= 1'b0;
                  mem_oe_q <= 1'b0;
               end else begin
                  mem_addr_q <= rd_addr;
                  rd_idx_q   <= rd_idx_q + 7'd1;
               end
            end

            S_DONE, S_ERROR: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b0;
               mem_cs_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               mem_oe_q   <= 1'b0;
            end

            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b0;
               mem_cs_q   <= 1'b0;
               mem_we_q   <= 1'b0;
               mem_oe_q   <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_cs     = mem_cs_q;
   assign mem_we     = mem_we_q;
   assign mem_oe     = mem_oe_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign word_count = word_count_q;
   assign cpu_pc     = 16'(BASE_ADDR);
   assign cpu_start  = cpu_start_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//    Directed bench for program_loader with a synchronous RAM model,
//    a negedge bus monitor and one task per scenario.

module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [13:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_cs, mem_we, mem_oe;
   logic [15:0] mem_rdata = '0;
   logic        done, pass, cpu_start;
   logic [6:0]  word_count;
   logic [15:0] cpu_pc;

   int total = 0;
   int bad = 0;

   program_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
      .mem_rdata(mem_rdata),
      .done(done), .pass(pass), .word_count(word_count),
      .cpu_pc(cpu_pc), .cpu_start(cpu_start)
   );

   always #5 clk = ~clk;

   // synchronous RAM, optional single-bit corruption of address 'h104 on read
   logic [15:0] ram [0:16383];
   bit corrupt = 1'b0;
   always @(posedge clk) begin
      if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_cs && mem_oe)
         mem_rdata <= ram[mem_addr] ^ ((corrupt && mem_addr == 14'h104) ? 16'h0100 : 16'h0000);
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [13:0] wa_log [$];
   logic [15:0] wd_log [$];
   int          wc_log [$];
   int          rd_cnt = 0, done_cnt = 0, cpus_cnt = 0, cs_cnt = 0, done_cyc = 0;
   logic        done_pass = 1'b0;

   always @(negedge clk) begin
      if (mem_cs) cs_cnt++;
      if (mem_cs && mem_we) begin
         wa_log.push_back(mem_addr);
         wd_log.push_back(mem_wdata);
         wc_log.push_back(cyc);
      end
      if (mem_cs && mem_oe) rd_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         done_pass = pass;
      end
      if (cpu_start) cpus_cnt++;
   end

   logic [15:0] fib [23] = '{
      16'h2128, 16'h312A, 16'h5252, 16'h837C, 16'hD5CE, 16'h594A, 16'h2F18, 16'h8862,
      16'hB77A, 16'h3FDC, 16'hF756, 16'h3732, 16'h2E88, 16'h65BA, 16'h9442, 16'hF9FC,
      16'h8E3E, 16'h883A, 16'h1678, 16'h0005, 16'h0009, 16'h0000, 16'hFFFF};

   task automatic clear_log();
      wa_log.delete();
      wd_log.delete();
      wc_log.delete();
      rd_cnt = 0; done_cnt = 0; cpus_cnt = 0; cs_cnt = 0;
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d, input logic l);
      int n;
      in_valid = 1'b1; in_data = d; in_last = l;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 50);
      total++;
      if (!in_ready) begin
         bad++;
         $display("FAIL send_word_ready got=%0b exp=1 data=%h", in_ready, d);
      end
      @(posedge clk); #1;
   endtask

   task automatic end_stream();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (done_cnt == 0 && n < lim) begin @(posedge clk); n++; end
      #1;
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL wait_done timeout got=0 exp=1 after %0d cycles", lim);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({in_ready, mem_cs, mem_we, mem_oe, done, pass, cpu_start} !== 7'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0", {in_ready, mem_cs, mem_we, mem_oe, done, pass, cpu_start});
      end
      total++;
      if ({mem_addr, mem_wdata, word_count} !== 37'b0) begin
         bad++; $display("FAIL reset_data got=%h/%h/%0d exp=0", mem_addr, mem_wdata, word_count);
      end
      total++;
      if (cpu_pc !== 16'h0100) begin bad++; $display("FAIL reset_pc got=%h exp=0100", cpu_pc); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_idle_ignore();
      clear_log();
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'h5555; in_last = 1'b1;
      repeat (5) @(posedge clk);
      #1 end_stream();
      @(posedge clk); #1;
      total++;
      if (cs_cnt !== 0) begin bad++; $display("FAIL idle_ignore cs_cycles got=%0d exp=0", cs_cnt); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%0b exp=0", in_ready); end
   endtask

   task automatic test_fib();
      int errs;
      clear_log();
      do_start();
      for (int i = 0; i < 23; i++) begin
         start = (i == 10);        // start during LOAD must be ignored
         send_word(fib[i], i == 22);
         start = 1'b0;
      end
      end_stream();
      wait_done(200);
      total++;
      if (wa_log.size() !== 23) begin bad++; $display("FAIL fib_nwrites got=%0d exp=23", wa_log.size()); end
      else begin
         errs = 0;
         for (int i = 0; i < 23; i++) begin
            if (wa_log[i] !== 14'h100 + 14'(2 * i) || wd_log[i] !== fib[i] || wc_log[i] !== wc_log[0] + i)
               errs++;
         end
         total++;
         if (errs !== 0) begin bad++; $display("FAIL fib_write_seq got=%0d bad entries exp=0", errs); end
         total++;
         if (done_cyc - wc_log[22] !== 25) begin
            bad++; $display("FAIL fib_verify_len got=%0d exp=25", done_cyc - wc_log[22]);
         end
      end
      total++;
      if (rd_cnt !== 23) begin bad++; $display("FAIL fib_reads got=%0d exp=23", rd_cnt); end
      total++;
      if (done_cnt !== 1 || done_pass !== 1'b1) begin
         bad++; $display("FAIL fib_done got=%0d/%0b exp=1/1", done_cnt, done_pass);
      end
      total++;
      if (cpus_cnt !== 1) begin bad++; $display("FAIL fib_cpu_start got=%0d exp=1", cpus_cnt); end
      total++;
      if (word_count !== 7'd23 || pass !== 1'b1 || cpu_pc !== 16'h0100) begin
         bad++; $display("FAIL fib_final got=%0d/%0b/%h exp=23/1/0100", word_count, pass, cpu_pc);
      end
   endtask

   task automatic test_single();
      clear_log();
      do_start();
      send_word(16'h1000, 1'b1);
      end_stream();
      wait_done(50);
      total++;
      if (wa_log.size() !== 1) begin bad++; $display("FAIL single_nwrites got=%0d exp=1", wa_log.size()); end
      else begin
         total++;
         if (wa_log[0] !== 14'h100 || wd_log[0] !== 16'h1000) begin
            bad++; $display("FAIL single_write got=%h/%h exp=100/1000", wa_log[0], wd_log[0]);
         end
         total++;
         if (done_cyc - wc_log[0] !== 3) begin
            bad++; $display("FAIL single_verify_len got=%0d exp=3", done_cyc - wc_log[0]);
         end
      end
      total++;
      if (rd_cnt !== 1) begin bad++; $display("FAIL single_reads got=%0d exp=1", rd_cnt); end
      total++;
      if (done_pass !== 1'b1 || word_count !== 7'd1 || cpus_cnt !== 1) begin
         bad++; $display("FAIL single_result got=%0b/%0d/%0d exp=1/1/1", done_pass, word_count, cpus_cnt);
      end
   endtask

   task automatic test_corrupt();
      clear_log();
      corrupt = 1'b1;
      do_start();
      send_word(16'h0011, 1'b0);
      send_word(16'h0022, 1'b0);
      send_word(16'h0033, 1'b0);
      send_word(16'h0044, 1'b1);
      end_stream();
      wait_done(50);
      corrupt = 1'b0;
      total++;
      if (done_cnt !== 1 || done_pass !== 1'b0) begin
         bad++; $display("FAIL corrupt_done got=%0d/%0b exp=1/0", done_cnt, done_pass);
      end
      total++;
      if (cpus_cnt !== 0) begin bad++; $display("FAIL corrupt_cpu_start got=%0d exp=0", cpus_cnt); end
      total++;
      if (rd_cnt !== 4) begin bad++; $display("FAIL corrupt_reads got=%0d exp=4", rd_cnt); end
   endtask

   task automatic test_overflow();
      clear_log();
      do_start();
      for (int i = 0; i < 65; i++) send_word(16'(i + 1), 1'b0);
      end_stream();
      wait_done(20);
      total++;
      if (wa_log.size() !== 64) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=64", wa_log.size()); end
      else begin
         total++;
         if (wa_log[63] !== 14'h17E || wd_log[63] !== 16'd64) begin
            bad++; $display("FAIL ovf_last_write got=%h/%h exp=17e/0040", wa_log[63], wd_log[63]);
         end
      end
      total++;
      if (done_cnt !== 1 || done_pass !== 1'b0 || cpus_cnt !== 0 || rd_cnt !== 0) begin
         bad++; $display("FAIL ovf_result got=%0d/%0b/%0d/%0d exp=1/0/0/0", done_cnt, done_pass, cpus_cnt, rd_cnt);
      end
      total++;
      if (word_count !== 7'd64 || in_ready !== 1'b0) begin
         bad++; $display("FAIL ovf_final got=%0d/%0b exp=64/0", word_count, in_ready);
      end
   endtask

   task automatic test_toggle();
      clear_log();
      do_start();
      send_word(16'hFFFF, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      send_word(16'h0002, 1'b1);
      end_stream();
      wait_done(50);
      total++;
      if (wa_log.size() !== 2) begin bad++; $display("FAIL toggle_nwrites got=%0d exp=2", wa_log.size()); end
      else begin
         total++;
         if (wa_log[0] !== 14'h100 || wa_log[1] !== 14'h102 || wc_log[1] - wc_log[0] !== 2) begin
            bad++; $display("FAIL toggle_writes got=%h/%h gap=%0d exp=100/102 gap=2", wa_log[0], wa_log[1], wc_log[1] - wc_log[0]);
         end
      end
      total++;
      if (ram[14'h100] !== 16'hFFFF || ram[14'h102] !== 16'h0002) begin
         bad++; $display("FAIL toggle_ram got=%h/%h exp=ffff/0002", ram[14'h100], ram[14'h102]);
      end
      total++;
      if (done_pass !== 1'b1 || cpus_cnt !== 1) begin
         bad++; $display("FAIL toggle_pass got=%0b/%0d exp=1/1", done_pass, cpus_cnt);
      end
   endtask

   task automatic test_reset_abort();
      int n0;
      clear_log();
      do_start();
      for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, mem_cs, mem_we, mem_oe, done, pass, cpu_start} !== 7'b0 ||
          {mem_addr, mem_wdata, word_count} !== 37'b0) begin
         bad++; $display("FAIL abort_outputs got=%b/%h/%h/%0d exp=0",
            {in_ready, mem_cs, mem_we, mem_oe, done, pass, cpu_start}, mem_addr, mem_wdata, word_count);
      end
      n0 = wa_log.size();
      cs_cnt = 0;
      repeat (4) @(posedge clk);
      #1 end_stream();
      total++;
      if (cs_cnt !== 0 || wa_log.size() !== n0) begin
         bad++; $display("FAIL abort_no_access got=%0d cs cycles exp=0", cs_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_restart_ready got=%0b exp=1", in_ready); end
      clear_log();
      send_word(16'hABCD, 1'b1);
      end_stream();
      wait_done(50);
      total++;
      if (wa_log.size() !== 1 || wa_log[0] !== 14'h100) begin
         bad++; $display("FAIL abort_reload got=%0d writes exp=1 at 100", wa_log.size());
      end
      total++;
      if (done_pass !== 1'b1 || word_count !== 7'd1) begin
         bad++; $display("FAIL abort_reload_pass got=%0b/%0d exp=1/1", done_pass, word_count);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle_ignore();
      test_fib();
      test_single();
      test_corrupt();
      test_overflow();
      test_toggle();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
